ram_march_tester: RTL and testbench
===================================

Name: ram_march_tester

Overview:
- Initiator-side engine for the single-port RAM interface (clk, we, adr, din, dout) used by ram_top.
- On start, it runs a three-phase march test over all 2^N words: write a pattern, read/verify/write the inverse, then read/verify the inverse in descending order.
- It reports pass/fail, an error count, and details of the first failing word.
- Sits between a control/status source (bench or host FSM) and a ram_top instance, replacing hand-sequenced testbench stimulus.

Parameters:
- N, 4, address width; RAM depth = 2^N.
- M, 32, data width; M >= N required.
- RD_LAT, 1, RAM read latency in cycles (0 = asynchronous dout, 1 = registered-address RAM).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- seed  in  M  pattern base; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  valid from done until the next accepted start; 1 iff err_cnt == 0.
- err_cnt  out  N+2  mismatch count; saturates at all-ones.
- err_adr  out  N  address of first mismatch.
- err_exp  out  M  expected data of first mismatch.
- err_got  out  M  read data of first mismatch.
- ram_we  out  1  RAM write enable.
- ram_adr  out  N  RAM address.
- ram_din  out  M  RAM write data.
- ram_dout  in  M  RAM read data.

Behaviour:
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE; this takes effect on the next edge, including mid-run. There is no partial-state carry-over after reset.
- Pattern: P(a) = seed_q XOR zero-extended a.
- States: IDLE, W0, R1, W1, R2, FIN.
- IDLE:
  - start=1 captures seed and clears err_cnt, err_adr, err_exp, err_got and pass.
  - Next state is W0 with a=0.
- W0 (ascending, a=0..2^N-1), one cycle per word:
  - ram_we=1, ram_adr=a, ram_din=P(a).
  - After a=2^N-1, go to R1 with a=0. The address never wraps past the top.
- R1 (ascending):
  - ram_we=0 and ram_adr=a, held for RD_LAT+1 cycles.
  - On the last edge of the hold, compare ram_dout against P(a).
  - Then go to W1.
- W1:
  - One cycle: ram_we=1, ram_adr=a, ram_din=~P(a).
  - Then R1 at a+1. After a=2^N-1, go to R2 with a=2^N-1.
- R2 (descending):
  - Same read and hold as R1, but the compare is against ~P(a).
  - a decrements. After the compare at a=0, go to FIN.
- FIN:
  - done=1 and pass=(err_cnt==0) for one cycle; busy drops in the same cycle.
  - Then go to IDLE.
- Mismatch handling:
  - err_cnt increments, saturating at all-ones.
  - On the first mismatch only (err_cnt==0 before the increment), latch err_adr, err_exp and err_got.
- ram_we is 0 in IDLE, R1, R2 and FIN.
- ram_din is don't-care when ram_we=0 but must hold its last value (no X).
- start while busy is ignored: no restart and no seed change.
- start on the same edge as done (FIN) is ignored; start is accepted from IDLE onward.
- Total cycles from the first W0 cycle to done: 2^N + 2^N*(RD_LAT+2) + 2^N*(RD_LAT+1).
  - N=4, RD_LAT=1: 16 + 48 + 32 = 96.
  - N=4, RD_LAT=0: 64.

Test Plan:
- Fault-free ram_top (N=4, M=32, RD_LAT=1), seed=32'hA5A50000, one-cycle start.
  - Required: busy for exactly 96 cycles, then a done pulse with pass=1 and err_cnt=0.
  - Afterwards the RAM at adr 1 holds 32'h5A5AFFFE and at adr F holds 32'h5A5AFFF0.
- Same setup, but the bench forces ram_dout bit0 to 0 whenever ram_adr==1.
  - Required: err_cnt=1, err_adr=1, err_exp=32'hA5A50001, err_got=32'hA5A50000, pass=0.
  - The R2 phase read at adr 1 expects 5A5AFFFE, so the forced bit0 does not cause a second error.
- start re-pulsed at cycles 10 and 50 of a run.
  - Required: completion still at cycle 96 and the seed is unchanged.
  - A start one cycle after done launches a fresh 96-cycle run with cleared error fields.
- rst_n=0 for one cycle at run cycle 40.
  - Required: at the next edge ram_we=0, busy=0 and all status fields are 0.
  - A subsequent start runs the full 96 cycles and passes.
- RD_LAT=0 with an asynchronous-read RAM model, seed=32'hFFFFFFFF.
  - Required: done after 64 cycles with pass=1.
  - In R2, ram_adr steps F,E,…,0 with no access at F after 0, i.e. no wrap.

Source files
------------

// File: rtl/ram_march_tester.sv
// Three-phase march test engine driving a single-port RAM: write P(a), read/verify/write ~P(a)
// ascending, then read/verify ~P(a) descending. Reports pass/fail, error count and first failure.
module ram_march_tester #(
    parameter int N      = 4,
    parameter int M      = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [M-1:0]     seed,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N+1:0]     err_cnt,
    output logic [N-1:0]     err_adr,
    output logic [M-1:0]     err_exp,
    output logic [M-1:0]     err_got,
    output logic             ram_we,
    output logic [N-1:0]     ram_adr,
    output logic [M-1:0]     ram_din,
    input  logic [M-1:0]     ram_dout
);

    typedef enum logic [2:0] {IDLE, W0, R1, W1, R2, FIN} state_t;

    localparam int              HW        = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RD_LAT);
    localparam logic [N-1:0]    A_TOP     = '1;

    function automatic logic [M-1:0] pattern(input logic [M-1:0] s, input logic [N-1:0] a);
        return s ^ M'(a);
    endfunction

    state_t          state, state_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic [N-1:0]    adr_nxt;
    logic [M-1:0]    seed_q, seed_nxt;
    logic            cmp_en;
    logic [M-1:0]    cmp_exp;

    logic            mismatch;
    logic            we_d, busy_d, done_d, pass_d;
    logic [M-1:0]    din_d;
    logic [N+1:0]    err_cnt_d;
    logic [N-1:0]    err_adr_d;
    logic [M-1:0]    err_exp_d, err_got_d;

    // State and every output live in this one register process; ram_adr doubles as the
    // march address counter so the address seen by the RAM is always the one being tested.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only in clocked logic, so every flop samples pre-edge values.
        if (!rst_n) begin
            state   <= IDLE;
            hold    <= '0;
            seed_q  <= '0;
            ram_adr <= '0;
            ram_we  <= 1'b0;
            ram_din <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            err_adr <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            seed_q  <= seed_nxt;
            ram_adr <= adr_nxt;
            ram_we  <= we_d;
            ram_din <= din_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            err_cnt <= err_cnt_d;
            err_adr <= err_adr_d;
            err_exp <= err_exp_d;
            err_got <= err_got_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_nxt = state;
        adr_nxt   = ram_adr;
        hold_nxt  = hold;
        seed_nxt  = seed_q;
        cmp_en    = 1'b0;
        cmp_exp   = pattern(seed_q, ram_adr);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = W0;
                    adr_nxt   = '0;
                    hold_nxt  = '0;
                    seed_nxt  = seed;
                end
            end
            W0: begin
                if (ram_adr == A_TOP) begin
                    state_nxt = R1;
                    adr_nxt   = '0;
                end else begin
                    adr_nxt = ram_adr + N'(1);
                end
            end
            R1: begin
                if (hold == HOLD_LAST) begin
                    cmp_en    = 1'b1;
                    state_nxt = W1;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            W1: begin
                hold_nxt = '0;
                if (ram_adr == A_TOP) begin
                    state_nxt = R2;
                end else begin
                    state_nxt = R1;
                    adr_nxt   = ram_adr + N'(1);
                end
            end
            R2: begin
                cmp_exp = ~pattern(seed_q, ram_adr);
                if (hold == HOLD_LAST) begin
                    cmp_en   = 1'b1;
                    hold_nxt = '0;
                    if (ram_adr == '0) begin
                        state_nxt = FIN;
                    end else begin
                        adr_nxt = ram_adr - N'(1);
                    end
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values are derived from the next state so the registered outputs line up with it.
    always_comb begin
        we_d      = (state_nxt == W0) || (state_nxt == W1);
        busy_d    = (state_nxt == W0) || (state_nxt == R1) || (state_nxt == W1) || (state_nxt == R2);
        done_d    = (state_nxt == FIN);
        din_d     = ram_din;
        if (state_nxt == W0) begin
            din_d = pattern(seed_nxt, adr_nxt);
        end else if (state_nxt == W1) begin
            din_d = ~pattern(seed_nxt, adr_nxt);
        end

        mismatch  = cmp_en && (ram_dout != cmp_exp);
        err_cnt_d = err_cnt;
        err_adr_d = err_adr;
        err_exp_d = err_exp;
        err_got_d = err_got;
        pass_d    = pass;
        if (state == IDLE && start) begin
            err_cnt_d = '0;
            err_adr_d = '0;
            err_exp_d = '0;
            err_got_d = '0;
            pass_d    = 1'b0;
        end else if (mismatch) begin
            if (err_cnt != '1) begin
                err_cnt_d = err_cnt + (N+2)'(1);
            end
            if (err_cnt == '0) begin
                err_adr_d = ram_adr;
                err_exp_d = cmp_exp;
                err_got_d = ram_dout;
            end
        end
        // The final R2 compare lands on the same edge as entry to FIN, so use the updated count.
        if (state_nxt == FIN) begin
            pass_d = (err_cnt_d == '0);
        end
    end

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: two instances (RD_LAT=1 registered RAM, RD_LAT=0 async RAM),
// a march-level model of the expected access trace and error outcome, plus literal pins.
module tb_ram_march_tester;

    localparam int N = 4;
    localparam int M = 32;

    typedef struct packed {
        logic         we;
        logic [N-1:0] adr;
        logic [M-1:0] din;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b1;
    logic fault = 1'b0;
    logic [M-1:0] seed = '0;

    logic start1, start0;
    assign start1 = start & sel;
    assign start0 = start & ~sel;

    logic busy1, done1, pass1, we1, busy0, done0, pass0, we0;
    logic [N+1:0] err_cnt1, err_cnt0;
    logic [N-1:0] err_adr1, err_adr0, adr1, adr0;
    logic [M-1:0] err_exp1, err_got1, din1, dout1, err_exp0, err_got0, din0, dout0;

    always #5 clk = ~clk;

    ram_march_tester #(.N(N), .M(M), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .err_adr(err_adr1), .err_exp(err_exp1), .err_got(err_got1),
        .ram_we(we1), .ram_adr(adr1), .ram_din(din1), .ram_dout(dout1)
    );

    ram_march_tester #(.N(N), .M(M), .RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
        .err_adr(err_adr0), .err_exp(err_exp0), .err_got(err_got0),
        .ram_we(we0), .ram_adr(adr0), .ram_din(din0), .ram_dout(dout0)
    );

    // Registered-address RAM with optional stuck-at-0 on bit0 while address 1 is presented.
    logic [M-1:0] mem1 [16];
    logic [N-1:0] radr1 = '0;
    always @(posedge clk) begin
        if (we1) mem1[adr1] <= din1;
        radr1 <= adr1;
    end
    assign dout1 = mem1[radr1] & ~((fault && adr1 == 4'd1) ? 32'd1 : 32'd0);

    // Asynchronous-read RAM.
    logic [M-1:0] mem0 [16];
    always @(posedge clk) begin
        if (we0) mem0[adr0] <= din0;
    end
    assign dout0 = mem0[adr0];

    logic         m_busy, m_done, m_pass, m_we;
    logic [N+1:0] m_cnt;
    logic [N-1:0] m_adr, m_eadr;
    logic [M-1:0] m_din, m_eexp, m_egot;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_we   = sel ? we1 : we0;
    assign m_cnt  = sel ? err_cnt1 : err_cnt0;
    assign m_adr  = sel ? adr1 : adr0;
    assign m_eadr = sel ? err_adr1 : err_adr0;
    assign m_din  = sel ? din1 : din0;
    assign m_eexp = sel ? err_exp1 : err_exp0;
    assign m_egot = sel ? err_got1 : err_got0;

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Model of one run: the expected per-cycle RAM access trace and the error outcome.
    acc_t         exp_q[$];
    acc_t         mon_e;
    bit           mon_on = 1'b0;
    int           exp_cnt;
    logic [N-1:0] exp_adr;
    logic [M-1:0] exp_e, exp_g;
    logic         exp_pass;

    function automatic logic [M-1:0] pat(input logic [M-1:0] s, input int a);
        return s ^ 32'(a);
    endfunction

    task automatic note_read(input int a, input logic [M-1:0] e, input logic [M-1:0] g);
        if (e !== g) begin
            if (exp_cnt == 0) begin
                exp_adr = 4'(a);
                exp_e   = e;
                exp_g   = g;
            end
            if (exp_cnt < 63) exp_cnt++;
        end
    endtask

    task automatic build_model(input logic [M-1:0] s, input int lat, input bit flt);
        logic [M-1:0] m [16];
        logic [M-1:0] rd;
        exp_q.delete();
        exp_cnt = 0;
        exp_adr = '0;
        exp_e   = '0;
        exp_g   = '0;
        for (int a = 0; a < 16; a++) begin
            m[a] = pat(s, a);
            exp_q.push_back(acc_t'{1'b1, 4'(a), pat(s, a)});
        end
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k <= lat; k++) exp_q.push_back(acc_t'{1'b0, 4'(a), 32'h0});
            rd = m[a] & ~((flt && a == 1) ? 32'd1 : 32'd0);
            note_read(a, pat(s, a), rd);
            m[a] = ~pat(s, a);
            exp_q.push_back(acc_t'{1'b1, 4'(a), ~pat(s, a)});
        end
        for (int a = 15; a >= 0; a--) begin
            for (int k = 0; k <= lat; k++) exp_q.push_back(acc_t'{1'b0, 4'(a), 32'h0});
            rd = m[a] & ~((flt && a == 1) ? 32'd1 : 32'd0);
            note_read(a, ~pat(s, a), rd);
        end
        exp_pass = (exp_cnt == 0);
    endtask

    // Compare process: one trace entry per busy cycle, then the completion cycle.
    always @(posedge clk) begin
        #2;
        if (mon_on) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("trace", {m_busy, m_done, m_we, m_adr, (m_we ? m_din : 32'h0)},
                      {1'b1, 1'b0, mon_e.we, mon_e.adr, (mon_e.we ? mon_e.din : 32'h0)});
            end else begin
                check("fin", {m_done, m_busy, m_we, m_pass, m_cnt},
                      {1'b1, 1'b0, 1'b0, exp_pass, 6'(exp_cnt)});
                if (exp_cnt != 0) begin
                    check("first_err", {m_eadr, m_eexp, m_egot}, {exp_adr, exp_e, exp_g});
                end
                mon_on = 1'b0;
            end
        end
    end

    task automatic launch(input bit s, input logic [M-1:0] sd, input int lat, input bit flt);
        sel   = s;
        fault = flt;
        seed  = sd;
        build_model(sd, lat, flt);
        mon_on = 1'b1;
        start  = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
    endtask

    // Runs until done (bounded). pulse re-asserts start at busy cycles 10 and 50 with a
    // different seed; rst_at returns early at that busy cycle instead of waiting for done.
    task automatic run_wait(input string name, input int exp_busy, input bit pulse, input int rst_at);
        int nb;
        bit finished;
        nb = 0;
        finished = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_busy) nb++;
            if (m_done) begin
                finished = 1'b1;
                break;
            end
            if (rst_at != 0 && nb == rst_at) break;
            if (pulse && (nb == 10 || nb == 50)) begin
                start = 1'b1;
                seed  = ~seed;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #3;
        end
        start = 1'b0;
        if (rst_at == 0) begin
            check({name, "_done_seen"}, 128'(finished), 128'd1);
            check({name, "_busy_cycles"}, 128'(nb), 128'(exp_busy));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_outs1", {busy1, done1, pass1, we1, err_cnt1, err_adr1, adr1, err_exp1, err_got1, din1}, '0);
        check("reset_outs0", {busy0, done0, pass0, we0, err_cnt0, err_adr0, adr0, err_exp0, err_got0, din0}, '0);
        rst_n = 1'b1;
        @(posedge clk); #3;

        // Fault-free run.
        launch(1'b1, 32'hA5A50000, 1, 1'b0);
        run_wait("clean", 96, 1'b0, 0);
        check("clean_pass", {pass1, err_cnt1}, {1'b1, 6'd0});
        check("mem_adr1", mem1[1], 32'h5A5AFFFE);
        check("mem_adrF", mem1[15], 32'h5A5AFFF0);

        // Start during the done cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        check("fin_start_ignored", {busy1, done1, pass1}, {1'b0, 1'b0, 1'b1});
        @(posedge clk); #3;
        check("idle_hold", {busy1, pass1}, {1'b0, 1'b1});

        // Stuck bit0 on reads of address 1.
        launch(1'b1, 32'hA5A50000, 1, 1'b1);
        run_wait("fault", 96, 1'b0, 0);
        check("fault_cnt", err_cnt1, 6'd1);
        check("fault_adr", err_adr1, 4'd1);
        check("fault_exp", err_exp1, 32'hA5A50001);
        check("fault_got", err_got1, 32'hA5A50000);
        check("fault_pass", pass1, 1'b0);

        // Start one cycle after done, with ignored re-starts mid-run.
        @(posedge clk); #3;
        launch(1'b1, 32'hA5A50000, 1, 1'b0);
        check("fresh_clear", {pass1, err_cnt1, err_adr1, err_exp1, err_got1}, '0);
        run_wait("restart", 96, 1'b1, 0);
        check("restart_pass", pass1, 1'b1);

        // Synchronous reset in the middle of a run.
        @(posedge clk); #3;
        launch(1'b1, 32'hA5A50000, 1, 1'b0);
        run_wait("rst_run", 0, 1'b0, 40);
        mon_on = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        check("midrun_reset", {busy1, done1, pass1, we1, err_cnt1, err_adr1, adr1}, '0);
        check("midrun_reset_data", {err_exp1, err_got1, din1}, '0);
        launch(1'b1, 32'hA5A50000, 1, 1'b0);
        run_wait("post_rst", 96, 1'b0, 0);
        check("post_rst_pass", pass1, 1'b1);

        // Asynchronous-read RAM, RD_LAT=0.
        @(posedge clk); #3;
        launch(1'b0, 32'hFFFFFFFF, 0, 1'b0);
        run_wait("lat0", 64, 1'b0, 0);
        check("lat0_pass", {pass0, err_cnt0}, {1'b1, 6'd0});
        check("lat0_memF", mem0[15], 32'h0000000F);
        check("lat0_mem0", mem0[0], 32'h00000000);
        @(posedge clk); #3;
        check("lat0_idle", {busy0, done0}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
